// File: rtl/ctrl_seq_if.sv
// Bundle between ctrl_seq and the fetch/datapath side: Start, Instruction and
// Zero flow into the sequencer; decode and handshake strobes flow out.
interface ctrl_seq_if #(
  parameter int IW     = 9,
  parameter int ALUOPW = 4
);
  logic              Start;
  logic [IW-1:0]     Instruction;
  logic              Zero;
  logic              Jump;
  logic              BranchEn;
  logic              MemWrEn;
  logic              MemRdEn;
  logic              RegWrEn;
  logic              Ack;
  logic              Stall;
  logic              PcAdvance;
  logic [ALUOPW-1:0] ALUOp;
  logic [15:0]       InstrCount;

  modport master (
    output Start, Instruction, Zero,
    input  Jump, BranchEn, MemWrEn, MemRdEn, RegWrEn, Ack, Stall, PcAdvance,
           ALUOp, InstrCount
  );

  modport slave (
    input  Start, Instruction, Zero,
    output Jump, BranchEn, MemWrEn, MemRdEn, RegWrEn, Ack, Stall, PcAdvance,
           ALUOp, InstrCount
  );
endinterface

// File: rtl/ctrl_seq.sv
// Clocked control sequencer: opcode decode, multi-cycle LW/SW stalling, HALT/Ack.
// Optional retired-instruction counter enabled by CTRL_SEQ_INSTR_COUNT_EN.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int OPW     = 4,
  parameter int ALUOPW  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  ctrl_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALT} state_t;

  localparam int             CW   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(MEM_LAT - 1);

  localparam logic [OPW-1:0] OP_LW   = OPW'(0);
  localparam logic [OPW-1:0] OP_LOOP = OPW'(9);
  localparam logic [OPW-1:0] OP_GOTO = OPW'(11);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(12);
  localparam logic [OPW-1:0] OP_RB   = OPW'(13);
  localparam logic [OPW-1:0] OP_SW   = OPW'(14);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OPW-1:0]    opc;
  logic              jump, branch_en, mem_wr, mem_rd, reg_wr, ack, stall, pc_adv;
  logic [ALUOPW-1:0] alu_op;
  logic              unused_instr_bits;

  assign opc               = bus.Instruction[IW-1 -: OPW];
  assign unused_instr_bits = ^bus.Instruction[IW-OPW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    jump      = 1'b0;
    branch_en = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    reg_wr    = 1'b0;
    ack       = 1'b0;
    stall     = 1'b0;
    pc_adv    = 1'b0;
    alu_op    = '0;
    case (state_q)
      IDLE: if (bus.Start) state_d = RUN;
      RUN: begin
        case (opc)
          OP_LW: begin
            mem_rd = 1'b1;
            if (MEM_LAT == 1) begin
              reg_wr = 1'b1;
              pc_adv = 1'b1;
            end else begin
              stall   = 1'b1;
              state_d = MEM_WAIT;
              cnt_d   = CW'(1);
            end
          end
          OP_SW: begin
            mem_wr = 1'b1;
            if (MEM_LAT == 1) pc_adv = 1'b1;
            else begin
              stall   = 1'b1;
              state_d = MEM_WAIT;
              cnt_d   = CW'(1);
            end
          end
          OP_LOOP, OP_BEQ: begin
            alu_op    = ALUOPW'(opc);
            branch_en = bus.Zero;
            pc_adv    = 1'b1;
          end
          OP_GOTO: begin
            jump   = 1'b1;
            pc_adv = 1'b1;
          end
          OP_RB:   pc_adv = 1'b1;
          OP_HALT: state_d = HALT;
          default: begin
            // Remaining opcodes (1-8, 10) are register-writing ALU ops.
            reg_wr = 1'b1;
            alu_op = ALUOPW'(opc);
            pc_adv = 1'b1;
          end
        endcase
      end
      MEM_WAIT: begin
        // Instruction is held by the fetch unit, so the opcode still tells LW from SW.
        mem_rd = (opc == OP_LW);
        if (cnt_q == LAST) begin
          pc_adv  = 1'b1;
          reg_wr  = (opc == OP_LW);
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      HALT: begin
        ack = 1'b1;
        if (bus.Start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every strobe in the same cycle so an aborted LW never writes back.
    if (Reset) begin
      jump      = 1'b0;
      branch_en = 1'b0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      reg_wr    = 1'b0;
      ack       = 1'b0;
      stall     = 1'b0;
      pc_adv    = 1'b0;
      alu_op    = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Jump      = jump;
  assign bus.BranchEn  = branch_en;
  assign bus.MemWrEn   = mem_wr;
  assign bus.MemRdEn   = mem_rd;
  assign bus.RegWrEn   = reg_wr;
  assign bus.Ack       = ack;
  assign bus.Stall     = stall;
  assign bus.PcAdvance = pc_adv;
  assign bus.ALUOp     = alu_op;

`ifdef CTRL_SEQ_INSTR_COUNT_EN
  logic [15:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if ((state_q == IDLE || state_q == HALT) && bus.Start) icnt_d = '0;
    else if (pc_adv && icnt_q != 16'hFFFF)                 icnt_d = icnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) icnt_q <= '0;
    else       icnt_q <= icnt_d;
  end

  assign bus.InstrCount = Reset ? 16'h0 : icnt_q;
`else
  assign bus.InstrCount = 16'h0;
`endif
endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: two instances (MEM_LAT=2 and MEM_LAT=3) driven
// in turn from directed vectors; a negedge monitor pops and compares expectations.
module tb_ctrl_seq;
  localparam logic [7:0] F_J = 8'h80, F_BR = 8'h40, F_MW = 8'h20, F_MR = 8'h10,
                         F_RW = 8'h08, F_ACK = 8'h04, F_ST = 8'h02, F_PA = 8'h01;

  typedef struct packed {
    logic [7:0]  fl;   // {Jump,BranchEn,MemWrEn,MemRdEn,RegWrEn,Ack,Stall,PcAdvance}
    logic [3:0]  alu;
    logic [15:0] ic;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
    int    d;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       zero = 1'b0;
  logic [8:0] instr = '0;
  int         sel = 0;
  logic       rst2, rst3;
  exp_t       out2, out3;
  item_t      q[$];
  int         checks = 0;
  int         passed = 0;
  logic [15:0] exp_ic = '0;

  always #5 clk = ~clk;

  ctrl_seq_if #(.IW(9), .ALUOPW(4)) if2 ();
  ctrl_seq_if #(.IW(9), .ALUOPW(4)) if3 ();

  assign rst2 = rst | (sel != 0);
  assign rst3 = rst | (sel != 1);
  assign if2.Start = start;  assign if2.Instruction = instr;  assign if2.Zero = zero;
  assign if3.Start = start;  assign if3.Instruction = instr;  assign if3.Zero = zero;

  ctrl_seq #(.IW(9), .OPW(4), .ALUOPW(4), .MEM_LAT(2)) u_l2 (.Clk(clk), .Reset(rst2), .bus(if2.slave));
  ctrl_seq #(.IW(9), .OPW(4), .ALUOPW(4), .MEM_LAT(3)) u_l3 (.Clk(clk), .Reset(rst3), .bus(if3.slave));

  assign out2 = {if2.Jump, if2.BranchEn, if2.MemWrEn, if2.MemRdEn, if2.RegWrEn, if2.Ack,
                 if2.Stall, if2.PcAdvance, if2.ALUOp, if2.InstrCount};
  assign out3 = {if3.Jump, if3.BranchEn, if3.MemWrEn, if3.MemRdEn, if3.RegWrEn, if3.Ack,
                 if3.Stall, if3.PcAdvance, if3.ALUOp, if3.InstrCount};

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    item_t it;
    exp_t  got;
    if (q.size() > 0) begin
      it  = q.pop_front();
      got = (it.d == 1) ? out3 : out2;
      checks++;
      if (got !== it.e)
        $display("FAIL %s (L%0d): got fl=%b alu=%h ic=%0d, expected fl=%b alu=%h ic=%0d",
                 it.nm, it.d + 2, got.fl, got.alu, got.ic, it.e.fl, it.e.alu, it.e.ic);
      else passed++;
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string nm, input int d, input logic s, input logic r,
                     input logic [8:0] ins, input logic z, input logic [7:0] f,
                     input logic [3:0] alu);
    item_t it;
    @(posedge clk); #1;
    sel = d; start = s; rst = r; instr = ins; zero = z;
    it.nm = nm;
    it.d  = d;
    it.e.fl  = f;
    it.e.alu = alu;
`ifdef CTRL_SEQ_INSTR_COUNT_EN
    it.e.ic  = r ? 16'h0 : exp_ic;
    if (r || s)       exp_ic = '0;
    else if (f[0])    exp_ic = exp_ic + 16'd1;
`else
    it.e.ic  = 16'h0;
`endif
    q.push_back(it);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- MEM_LAT = 2 instance ----
    cyc("reset0",   0, 0, 1, 9'h000, 0, 8'h00, 4'h0);
    cyc("reset1",   0, 0, 1, 9'h000, 0, 8'h00, 4'h0);
    cyc("idle",     0, 0, 0, 9'b0000_00101, 0, 8'h00, 4'h0);
    cyc("start",    0, 1, 0, 9'b0011_00000, 0, 8'h00, 4'h0);
    cyc("and",      0, 0, 0, 9'b0011_00000, 0, F_RW | F_PA, 4'h3);
    cyc("lw_c1",    0, 0, 0, 9'b0000_00101, 0, F_MR | F_ST, 4'h0);
    cyc("lw_c2",    0, 0, 0, 9'b0000_00101, 0, F_MR | F_RW | F_PA, 4'h0);
    cyc("sw_c1",    0, 0, 0, 9'b1110_00011, 0, F_MW | F_ST, 4'h0);
    cyc("sw_c2",    0, 0, 0, 9'b1110_00011, 0, F_PA, 4'h0);
    cyc("beq_z1",   0, 0, 0, 9'b1100_00001, 1, F_BR | F_PA, 4'hC);
    cyc("beq_z0",   0, 0, 0, 9'b1100_00001, 0, F_PA, 4'hC);
    cyc("loop_z1",  0, 0, 0, 9'b1001_00010, 1, F_BR | F_PA, 4'h9);
    cyc("goto",     0, 0, 0, 9'b1011_00100, 1, F_J | F_PA, 4'h0);
    cyc("rb",       0, 0, 0, 9'b1101_00000, 0, F_PA, 4'h0);
    cyc("alu1",     0, 0, 0, 9'b0001_00000, 0, F_RW | F_PA, 4'h1);
    cyc("alu8",     0, 0, 0, 9'b1000_00000, 0, F_RW | F_PA, 4'h8);
    cyc("alu10",    0, 0, 0, 9'b1010_00000, 1, F_RW | F_PA, 4'hA);
    cyc("halt",     0, 0, 0, 9'b1111_00000, 0, 8'h00, 4'h0);
    for (int i = 0; i < 5; i++)
      cyc("halt_ack", 0, 0, 0, 9'b0011_00000, 1, F_ACK, 4'h0);
    cyc("halt_start", 0, 1, 0, 9'b0011_00000, 0, F_ACK, 4'h0);
    cyc("run_and",  0, 0, 0, 9'b0011_00000, 0, F_RW | F_PA, 4'h3);
    cyc("run_alu2", 0, 0, 0, 9'b0010_00000, 0, F_RW | F_PA, 4'h2);
    cyc("run_alu4", 0, 0, 0, 9'b0100_00000, 0, F_RW | F_PA, 4'h4);
    cyc("cnt3_rb",  0, 0, 0, 9'b1101_00000, 0, F_PA, 4'h0);
    // ---- MEM_LAT = 3 instance ----
    cyc("l3_reset", 1, 0, 1, 9'h000, 0, 8'h00, 4'h0);
    cyc("l3_start", 1, 1, 0, 9'b1110_00000, 0, 8'h00, 4'h0);
    cyc("sw3_c1",   1, 0, 0, 9'b1110_00000, 0, F_MW | F_ST, 4'h0);
    cyc("sw3_c2",   1, 0, 0, 9'b1110_00000, 0, F_ST, 4'h0);
    cyc("sw3_c3",   1, 0, 0, 9'b1110_00000, 0, F_PA, 4'h0);
    cyc("lw3_c1",   1, 0, 0, 9'b0000_00101, 0, F_MR | F_ST, 4'h0);
    cyc("lw3_rst",  1, 0, 1, 9'b0000_00101, 0, 8'h00, 4'h0);
    cyc("lw3_abrt", 1, 0, 0, 9'b0000_00101, 0, 8'h00, 4'h0);
    cyc("lw3_idle", 1, 0, 0, 9'b0000_00101, 0, 8'h00, 4'h0);
    cyc("l3_start2",1, 1, 0, 9'b0000_00101, 0, 8'h00, 4'h0);
    cyc("lw3_c1b",  1, 0, 0, 9'b0000_00101, 0, F_MR | F_ST, 4'h0);
    cyc("lw3_c2b",  1, 0, 0, 9'b0000_00101, 0, F_MR | F_ST, 4'h0);
    cyc("lw3_c3b",  1, 0, 0, 9'b0000_00101, 0, F_MR | F_RW | F_PA, 4'h0);
    cyc("l3_and",   1, 0, 0, 9'b0011_00000, 0, F_RW | F_PA, 4'h3);
    cyc("l3_halt",  1, 0, 0, 9'b1111_00000, 0, 8'h00, 4'h0);
    cyc("l3_ack",   1, 0, 0, 9'b0000_00000, 0, F_ACK, 4'h0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) $display("FAIL drain: %0d expectations left, expected 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
